// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and default DCCM window for the load/store controller
package lsu_pkg;
    typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} lsu_size_e;
    typedef enum logic [2:0] {IDLE, ERR, LD_RD, LD_DATA, ST_WR, RMW_RD, RMW_MRG, RMW_WR} lsu_state_e;
    localparam logic [31:0] DCCM_BASE_DEF = 32'hF004_0000;
    localparam logic [31:0] DCCM_SIZE_DEF = 32'h0001_0000;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: extracts/extends a load lane and merges a store lane into a full word
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);
    logic [4:0]  sh;
    logic [31:0] lane;
    logic [31:0] mask;
    always_comb begin
        sh      = {offset, 3'b000};
        lane    = word >> sh;
        mask    = (size == BYTE ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
        ld_data = size == BYTE ? {{24{lane[7] & ~is_unsigned}}, lane[7:0]} :
                  size == HALF ? {{16{lane[15] & ~is_unsigned}}, lane[15:0]} : word;
        st_word = size == WORD ? wdata : (word & ~mask) | ((wdata << sh) & mask);
    end
endmodule

// File: rtl/dccm_lsu_ctrl.sv
// dccm_lsu_ctrl: one-at-a-time load/store sequencer for the DCCM, read-modify-write for sub-word stores
module dccm_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter logic [31:0] DCCM_BASE = DCCM_BASE_DEF,
    parameter logic [31:0] DCCM_SIZE = DCCM_SIZE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        dccm_wren,
    output logic        dccm_rden,
    output logic [31:0] dccm_wr_addr,
    output logic [31:0] dccm_wr_data,
    input  logic [31:0] dccm_rd_data
);
    lsu_state_e  state;
    logic [1:0]  a_off;
    logic [1:0]  a_size;
    logic        a_uns;
    logic [31:0] a_wdata;
    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic [32:0] a_rel;
    logic        bad;

    lsu_lane_align u_align (
        .word        (dccm_rd_data),
        .wdata       (a_wdata),
        .offset      (a_off),
        .size        (a_size),
        .is_unsigned (a_uns),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    always_comb begin
        a_rel = {1'b0, req_addr} - {1'b0, DCCM_BASE};
        bad   = req_size == 2'b11 || (req_size == HALF && req_addr[0]) ||
                (req_size == WORD && req_addr[1:0] != 2'b00) || a_rel >= {1'b0, DCCM_SIZE};
    end

    assign rsp_rdata = state == LD_DATA ? ld_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            dccm_wren    <= 1'b0;
            dccm_rden    <= 1'b0;
            dccm_wr_addr <= '0;
            dccm_wr_data <= '0;
            a_off        <= '0;
            a_size       <= '0;
            a_uns        <= 1'b0;
            a_wdata      <= '0;
        end else begin
            dccm_wren <= 1'b0;
            dccm_rden <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        a_off     <= req_addr[1:0];
                        a_size    <= req_size;
                        a_uns     <= req_unsigned;
                        a_wdata   <= req_wdata;
                        if (bad) begin
                            state     <= ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            dccm_wr_addr <= {req_addr[31:2], 2'b00};
                            if (!req_we) begin
                                state     <= LD_RD;
                                dccm_rden <= 1'b1;
                            end else if (req_size == WORD) begin
                                state        <= ST_WR;
                                dccm_wren    <= 1'b1;
                                dccm_wr_data <= req_wdata;
                                rsp_valid    <= 1'b1;
                            end else begin
                                state     <= RMW_RD;
                                dccm_rden <= 1'b1;
                            end
                        end
                    end
                end
                LD_RD: begin
                    state     <= LD_DATA;
                    rsp_valid <= 1'b1;
                end
                RMW_RD: state <= RMW_MRG;
                // read data is valid now; the merged word becomes the write data
                RMW_MRG: begin
                    state        <= RMW_WR;
                    dccm_wr_data <= st_word;
                    dccm_wren    <= 1'b1;
                    rsp_valid    <= 1'b1;
                end
                ERR, LD_DATA, ST_WR, RMW_WR: begin
                    state        <= IDLE;
                    req_ready    <= 1'b1;
                    dccm_wr_addr <= '0;
                    dccm_wr_data <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dccm_lsu_ctrl.sv
// tb_dccm_lsu_ctrl: vector table plus scoreboard for the DCCM load/store controller
module tb_dccm_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        dccm_wren;
    logic        dccm_rden;
    logic [31:0] dccm_wr_addr;
    logic [31:0] dccm_wr_data;
    logic [31:0] dccm_rd_data = '0;

    dccm_lsu_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .dccm_wren    (dccm_wren),
        .dccm_rden    (dccm_rden),
        .dccm_wr_addr (dccm_wr_addr),
        .dccm_wr_data (dccm_wr_data),
        .dccm_rd_data (dccm_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] wr;
        int          lat;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    vec_t        v[17];
    logic [31:0] mem [0:16383];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rden_cyc = -1;
    int          wren_cyc = -1;
    int          rden_cnt = 0;
    int          wren_cnt = 0;
    logic [31:0] wr_data_s = '0;
    logic [31:0] wr_addr_s = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dccm_rden) dccm_rd_data <= mem[dccm_wr_addr[15:2]];
        if (dccm_wren) mem[dccm_wr_addr[15:2]] <= dccm_wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dccm_rden) begin
                rden_cyc = cyc;
                rden_cnt++;
            end
            if (dccm_wren) begin
                wren_cyc  = cyc;
                wren_cnt++;
                wr_data_s = dccm_wr_data;
                wr_addr_s = dccm_wr_addr;
            end
            if (dccm_rden && dccm_wren) chk("strobes_exclusive", 32'(dccm_rden & dccm_wren), 32'd0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int b = 0;
        while (!req_ready && b < 20) begin
            tick();
            b++;
        end
        if (!req_ready) chk(name, 32'(req_ready), 32'd1);
    endtask

    task automatic wait_rsp(input string name);
        int b = 0;
        while (q.size() != 0 && b < 10) begin
            tick();
            b++;
        end
        if (q.size() != 0) begin
            chk(name, 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    task automatic do_req(input vec_t x, output int t);
        wait_ready("ready_timeout");
        req_we       = x.we;
        req_size     = x.size;
        req_unsigned = x.uns;
        req_addr     = x.addr;
        req_wdata    = x.wdata;
        req_valid    = 1'b1;
        t = cyc;
        q.push_back('{t + x.lat, x.err, x.rdata});
        tick();
        req_valid = 1'b0;
        wait_rsp("rsp_timeout");
    endtask

    initial begin
        int t;
        int rc0;
        int wc0;
        int ts[3];
        logic [31:0] bb_addr[3];
        logic [31:0] bb_data[3];
        bb_addr = '{32'hF004_0050, 32'hF004_0054, 32'hF004_0058};
        bb_data = '{32'h0102_0304, 32'h0A0B_0C0D, 32'hF0E0_D0C0};
        mem[12'h008] <= 32'h1122_3344;
        mem[12'h00C] <= 32'h80FF_7F01;
        mem[12'h010] <= 32'h5566_7788;
        mem[14'h3FFF] <= 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) mem[bb_addr[k][15:2]] <= bb_data[k];

        v[0]  = '{1'b1, 2'b10, 1'b0, 32'hF004_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'hDEAD_BEEF, 1};
        v[1]  = '{1'b0, 2'b10, 1'b0, 32'hF004_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 32'h0, 2};
        v[2]  = '{1'b1, 2'b00, 1'b0, 32'hF004_0022, 32'h0000_00AA, 1'b0, 32'h0, 32'h11AA_3344, 3};
        v[3]  = '{1'b0, 2'b10, 1'b0, 32'hF004_0020, 32'h0, 1'b0, 32'h11AA_3344, 32'h0, 2};
        v[4]  = '{1'b0, 2'b00, 1'b0, 32'hF004_0031, 32'h0, 1'b0, 32'h0000_007F, 32'h0, 2};
        v[5]  = '{1'b0, 2'b00, 1'b0, 32'hF004_0032, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h0, 2};
        v[6]  = '{1'b0, 2'b01, 1'b1, 32'hF004_0032, 32'h0, 1'b0, 32'h0000_80FF, 32'h0, 2};
        v[7]  = '{1'b0, 2'b01, 1'b0, 32'hF004_0032, 32'h0, 1'b0, 32'hFFFF_80FF, 32'h0, 2};
        v[8]  = '{1'b0, 2'b01, 1'b0, 32'hF004_0001, 32'h0, 1'b1, 32'h0, 32'h0, 1};
        v[9]  = '{1'b1, 2'b10, 1'b0, 32'hF005_0000, 32'h1234_5678, 1'b1, 32'h0, 32'h0, 1};
        v[10] = '{1'b1, 2'b11, 1'b0, 32'hF004_0010, 32'h0BAD_0BAD, 1'b1, 32'h0, 32'h0, 1};
        v[11] = '{1'b0, 2'b00, 1'b1, 32'hF004_0033, 32'h0, 1'b0, 32'h0000_0080, 32'h0, 2};
        v[12] = '{1'b1, 2'b01, 1'b0, 32'hF004_0032, 32'h1234_5678, 1'b0, 32'h0, 32'h5678_7F01, 3};
        v[13] = '{1'b0, 2'b10, 1'b0, 32'hF004_0030, 32'h0, 1'b0, 32'h5678_7F01, 32'h0, 2};
        v[14] = '{1'b0, 2'b10, 1'b0, 32'hF004_FFFC, 32'h0, 1'b0, 32'hCAFE_F00D, 32'h0, 2};
        v[15] = '{1'b0, 2'b10, 1'b0, 32'hF003_FFFC, 32'h0, 1'b1, 32'h0, 32'h0, 1};
        v[16] = '{1'b0, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 32'h0, 1};

        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_strobes", 32'({dccm_wren, dccm_rden}), 32'd0);
        chk("rst_wr_addr", dccm_wr_addr, 32'd0);
        chk("rst_wr_data", dccm_wr_data, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        for (int i = 0; i < 17; i++) begin
            rc0 = rden_cnt;
            wc0 = wren_cnt;
            do_req(v[i], t);
            if (v[i].err) begin
                chk("err_no_rden", 32'(rden_cnt), 32'(rc0));
                chk("err_no_wren", 32'(wren_cnt), 32'(wc0));
            end else if (!v[i].we) begin
                chk("ld_rden_cycle", 32'(rden_cyc), 32'(t + 1));
            end else begin
                if (v[i].size != 2'b10) chk("rmw_rden_cycle", 32'(rden_cyc), 32'(t + 1));
                chk("st_wren_cycle", 32'(wren_cyc), 32'(t + v[i].lat));
                chk("st_wr_data", wr_data_s, v[i].wr);
                chk("st_wr_addr", wr_addr_s, {v[i].addr[31:2], 2'b00});
            end
        end

        wc0 = wren_cnt;
        wait_ready("rst_seq_ready");
        req_we    = 1'b1;
        req_size  = 2'b00;
        req_addr  = 32'hF004_0041;
        req_wdata = 32'h0000_0099;
        req_valid = 1'b1;
        t = cyc;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_rden_seen", 32'(rden_cyc), 32'(t + 1));
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        chk("mid_rst_strobes", 32'({dccm_wren, dccm_rden}), 32'd0);
        chk("mid_rst_wr_addr", dccm_wr_addr, 32'd0);
        chk("mid_rst_wr_data", dccm_wr_data, 32'd0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        tick();
        chk("mid_rst_no_wren", 32'(wren_cnt), 32'(wc0));
        do_req('{1'b0, 2'b10, 1'b0, 32'hF004_0040, 32'h0, 1'b0, 32'h5566_7788, 32'h0, 2}, t);

        wait_ready("bb_ready");
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_ready("bb_wait");
            req_addr = bb_addr[k];
            ts[k] = cyc;
            q.push_back('{cyc + 2, 1'b0, bb_data[k]});
            tick();
            chk("bb_ready_low", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        wait_rsp("bb_rsp_timeout");
        chk("bb_spacing_01", 32'(ts[1] - ts[0]), 32'd3);
        chk("bb_spacing_12", 32'(ts[2] - ts[1]), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
